// File: rtl/bcpu_defs_pkg.sv
// rtl/bcpu_defs_pkg.sv - shared BCPU16 widths, address types and reset PC
package bcpu_defs;

  localparam int unsigned DEF_THREAD_BITS = 2;
  localparam int unsigned DEF_PC_WIDTH    = 10;
  localparam int unsigned DEF_RESET_PC    = 0;

  typedef logic [DEF_THREAD_BITS-1:0] thread_id_t;
  typedef logic [DEF_PC_WIDTH-1:0]    program_addr_t;

endpackage

// File: rtl/bcpu_pc_bank.sv
// rtl/bcpu_pc_bank.sv - per-thread PC flops, one read port, increment and jump/restart writes
module bcpu_pc_bank
  import bcpu_defs::*;
#(
  parameter int unsigned THREAD_BITS = DEF_THREAD_BITS,
  parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEF_RESET_PC)
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       CE,
  input  logic [THREAD_BITS-1:0]     rd_idx,
  output logic [PC_WIDTH-1:0]        rd_data,
  input  logic                       inc_we,
  input  logic [THREAD_BITS-1:0]     inc_idx,
  input  logic [PC_WIDTH-1:0]        inc_data,
  input  logic                       jmp_we,
  input  logic [THREAD_BITS-1:0]     jmp_idx,
  input  logic [PC_WIDTH-1:0]        jmp_data,
  input  logic [2**THREAD_BITS-1:0]  restart
);

  localparam int unsigned THREADS = 2**THREAD_BITS;

  logic [PC_WIDTH-1:0] pc_q [THREADS];

  assign rd_data = pc_q[rd_idx];

  // Restart beats jump, jump beats the issue increment on the same thread.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < THREADS; i++) pc_q[i] <= RESET_PC;
    end else if (CE) begin
      for (int i = 0; i < THREADS; i++) begin
        if (restart[i])
          pc_q[i] <= RESET_PC;
        else if (jmp_we && jmp_idx == THREAD_BITS'(i))
          pc_q[i] <= jmp_data;
        else if (inc_we && inc_idx == THREAD_BITS'(i))
          pc_q[i] <= inc_data;
      end
    end
  end

endmodule

// File: rtl/bcpu_pc_unit.sv
// rtl/bcpu_pc_unit.sv - round-robin thread PC issue with taken-jump redirect and bypass
module bcpu_pc_unit
  import bcpu_defs::*;
#(
  parameter int unsigned THREAD_BITS = DEF_THREAD_BITS,
  parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEF_RESET_PC)
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       CE,
  input  logic [2**THREAD_BITS-1:0]  THREAD_EN,
  input  logic [2**THREAD_BITS-1:0]  THREAD_RESTART,
  input  logic                       JUMP_EN,
  input  logic                       CONDITION_RESULT,
  input  logic [THREAD_BITS-1:0]     JUMP_THREAD,
  input  logic [PC_WIDTH-1:0]        JUMP_TARGET,
  output logic [PC_WIDTH-1:0]        FETCH_PC,
  output logic [THREAD_BITS-1:0]     FETCH_THREAD,
  output logic                       FETCH_VALID,
  output logic                       JUMP_TAKEN
);

  logic [THREAD_BITS-1:0] thread_cnt;
  logic [PC_WIDTH-1:0]    pc_rd;
  logic [PC_WIDTH-1:0]    base_pc;
  logic                   take;
  logic                   bypass;
  logic                   issue_valid;

  assign take        = JUMP_EN & CONDITION_RESULT & THREAD_EN[JUMP_THREAD];
  assign bypass      = take & (JUMP_THREAD == thread_cnt);
  assign base_pc     = bypass ? JUMP_TARGET : pc_rd;
  assign issue_valid = THREAD_EN[thread_cnt] & ~THREAD_RESTART[thread_cnt];

  // A bypassed jump lands through the increment port as target+1, so the
  // jump port only serves threads other than the one being issued.
  bcpu_pc_bank #(
    .THREAD_BITS (THREAD_BITS),
    .PC_WIDTH    (PC_WIDTH),
    .RESET_PC    (RESET_PC)
  ) u_pc_bank (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CE       (CE),
    .rd_idx   (thread_cnt),
    .rd_data  (pc_rd),
    .inc_we   (issue_valid),
    .inc_idx  (thread_cnt),
    .inc_data (base_pc + PC_WIDTH'(1)),
    .jmp_we   (take & ~bypass),
    .jmp_idx  (JUMP_THREAD),
    .jmp_data (JUMP_TARGET),
    .restart  (THREAD_RESTART)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      thread_cnt   <= '0;
      FETCH_PC     <= '0;
      FETCH_THREAD <= '0;
      FETCH_VALID  <= 1'b0;
      JUMP_TAKEN   <= 1'b0;
    end else if (CE) begin
      thread_cnt   <= thread_cnt + THREAD_BITS'(1);
      FETCH_PC     <= base_pc;
      FETCH_THREAD <= thread_cnt;
      FETCH_VALID  <= issue_valid;
      JUMP_TAKEN   <= take;
    end
  end

endmodule
